// File: rtl/mem_sorter.sv
// In-place register-array sorter: host write/read port while idle, one bubble-sort compare-and-swap per clock.
// Optional early termination when a pass makes no swaps: define SORTER_EARLY_EXIT_EN.
//
// state | meaning
// IDLE  | ready=1, host port writes/reads the array, start launches a sort
// SORT  | ready=0, engine walks pass p / compare j, host inputs ignored
module mem_sorter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       start,
  input  logic                       wr,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [WIDTH-1:0]           datain,
  input  logic                       descend,
  output logic [WIDTH-1:0]           dataout,
  output logic                       ready,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SORT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    p, j, last_j, j_inc;
  logic             desc_q;
  logic [WIDTH-1:0] word_a, word_b;
  logic             do_swap, end_pass, finish, start_sort;
`ifdef SORTER_EARLY_EXIT_EN
  logic             swap_flag;
`endif

  always_comb begin
    j_inc    = j + AW'(1);
    last_j   = AW'(DEPTH - 2) - p;
    word_a   = mem[j];
    word_b   = mem[j_inc];
    do_swap  = desc_q ? (word_a < word_b) : (word_a > word_b);
    end_pass = (j == last_j);
    finish   = end_pass && (p == AW'(DEPTH - 2));
`ifdef SORTER_EARLY_EXIT_EN
    // A swap on the pass's final compare still counts for that pass.
    if (end_pass && !(swap_flag || do_swap)) finish = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_sort = 1'b0;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          start_sort = 1'b1;
          state_nxt  = SORT;
        end
      end
      SORT: begin
        if (finish) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) done <= 1'b0;
    else       done <= (state == SORT) && finish;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      dataout <= '0;
      p       <= '0;
      j       <= '0;
      desc_q  <= 1'b0;
`ifdef SORTER_EARLY_EXIT_EN
      swap_flag <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (start_sort) begin
        desc_q <= descend;
        p      <= '0;
        j      <= '0;
`ifdef SORTER_EARLY_EXIT_EN
        swap_flag <= 1'b0;
`endif
      end else if (wr) begin
        mem[addr] <= datain;
      end else begin
        dataout <= mem[addr];
      end
    end else begin
      if (do_swap) begin
        mem[j]     <= word_b;
        mem[j_inc] <= word_a;
      end
      if (end_pass) begin
        j <= '0;
        p <= p + AW'(1);
`ifdef SORTER_EARLY_EXIT_EN
        swap_flag <= 1'b0;
`endif
      end else begin
        j <= j_inc;
`ifdef SORTER_EARLY_EXIT_EN
        swap_flag <= swap_flag | do_swap;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_sorter.sv
// Scoreboard bench for mem_sorter: an 8x8 instance for the main scenarios and a 4x16 instance for the small case.
// Expected sort durations follow SORTER_EARLY_EXIT_EN when the bench is built with it.
module tb_mem_sorter;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;

  logic        start = 1'b0, wr = 1'b0, descend = 1'b0;
  logic [2:0]  addr = '0;
  logic [7:0]  datain = '0;
  logic [7:0]  dataout;
  logic        ready, done;

  logic        start4 = 1'b0, wr4 = 1'b0, descend4 = 1'b0;
  logic [1:0]  addr4 = '0;
  logic [15:0] datain4 = '0;
  logic [15:0] dataout4;
  logic        ready4, done4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [$];
  logic [7:0]  model [8];
  logic [15:0] model4 [4];

  mem_sorter #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .nrst(nrst), .start(start), .wr(wr), .addr(addr), .datain(datain),
    .descend(descend), .dataout(dataout), .ready(ready), .done(done)
  );

  mem_sorter #(.WIDTH(16), .DEPTH(4)) dut4 (
    .clk(clk), .nrst(nrst), .start(start4), .wr(wr4), .addr(addr4), .datain(datain4),
    .descend(descend4), .dataout(dataout4), .ready(ready4), .done(done4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) check({tag, "_queue_empty"}, 32'd1, 32'd0);
    else check(tag, got, exp_q.pop_front());
  endtask

  task automatic wr_word(input int a, input logic [7:0] d);
    @(negedge clk);
    start = 1'b0; wr = 1'b1; addr = a[2:0]; datain = d;
    model[a] = d;
  endtask

  task automatic rd_word(input int a);
    @(negedge clk);
    start = 1'b0; wr = 1'b0; addr = a[2:0];
    exp_q.push_back({24'd0, model[a]});
    @(posedge clk); #1;
    pop_check("rd", {24'd0, dataout});
  endtask

  task automatic rd_all;
    for (int a = 0; a < 8; a++) rd_word(a);
  endtask

  // Reference: selection sort on the model array.
  task automatic model_sort(input logic desc);
    logic [7:0] t;
    int best;
    for (int i = 0; i < 7; i++) begin
      best = i;
      for (int k = i + 1; k < 8; k++)
        if (desc ? (model[k] > model[best]) : (model[k] < model[best])) best = k;
      t = model[i]; model[i] = model[best]; model[best] = t;
    end
  endtask

  function automatic int exp_len(input logic desc);
    int n;
    bit sw;
    logic [7:0] a [8];
    logic [7:0] t;
    n = 0;
    a = model;
`ifdef SORTER_EARLY_EXIT_EN
    for (int pp = 0; pp < 7; pp++) begin
      sw = 1'b0;
      for (int jj = 0; jj <= 6 - pp; jj++) begin
        n++;
        if (desc ? (a[jj] < a[jj+1]) : (a[jj] > a[jj+1])) begin
          t = a[jj]; a[jj] = a[jj+1]; a[jj+1] = t; sw = 1'b1;
        end
      end
      if (!sw) break;
    end
`else
    sw = 1'b0;
    t = a[0];
    n = 28;
`endif
    return n;
  endfunction

  task automatic run_sort(input logic desc, input bit noise);
    int cycles, done_seen, want;
    logic [7:0] held;
    want = exp_len(desc);
    @(negedge clk);
    wr = 1'b0; start = 1'b1; descend = desc;
    @(negedge clk);
    start = 1'b0;
    held = dataout;
    cycles = 0; done_seen = 0;
    while (ready === 1'b0 && cycles < 200) begin
      cycles++;
      if (done !== 1'b0) done_seen++;
      if (noise) begin
        check("hold_dout", {24'd0, dataout}, {24'd0, held});
        wr = cycles[0]; start = ~cycles[0]; addr = 3'd0; datain = 8'hAA; descend = ~desc;
      end
      @(negedge clk);
    end
    wr = 1'b0; start = 1'b0; descend = desc;
    check("sort_len", cycles, want);
    check("done_in_sort", done_seen, 0);
    check("done_rise", {31'd0, done}, 1);
    if (noise) check("hold_dout_end", {24'd0, dataout}, {24'd0, held});
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 0);
    check("no_restart", {31'd0, ready}, 1);
    model_sort(desc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v1 [8] = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
    logic [7:0] v2 [8] = '{8'd3, 8'd3, 8'd0, 8'd255, 8'd7, 8'd3, 8'd0, 8'd1};
    logic [7:0] v3 [8] = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4};
    int cycles;

    // Reset pulse mid-cycle
    #12 nrst = 1'b0;
    #15 nrst = 1'b1;
    for (int a = 0; a < 8; a++) model[a] = '0;
    for (int a = 0; a < 4; a++) model4[a] = '0;
    #1;
    check("rst_ready", {31'd0, ready}, 1);
    check("rst_done", {31'd0, done}, 0);
    check("rst_dout", {24'd0, dataout}, 0);
    rd_all();

    // Ascending sort
    for (int a = 0; a < 8; a++) wr_word(a, v1[a]);
    run_sort(1'b0, 1'b0);
    rd_all();

    // Descending with duplicates
    for (int a = 0; a < 8; a++) wr_word(a, v2[a]);
    run_sort(1'b1, 1'b0);
    rd_all();

    // Host inputs toggled throughout the sort
    for (int a = 0; a < 8; a++) wr_word(a, v3[a]);
    rd_word(5);
    run_sort(1'b0, 1'b1);
    rd_all();

    // Already sorted input
    for (int a = 0; a < 8; a++) wr_word(a, 8'(a));
    run_sort(1'b0, 1'b0);
    rd_all();

    // Reset in the middle of a sort
    for (int a = 0; a < 8; a++) wr_word(a, v1[a]);
    @(negedge clk);
    wr = 1'b0; start = 1'b1; descend = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy", {31'd0, ready}, 0);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, ready}, 1);
    check("mid_rst_done", {31'd0, done}, 0);
    check("mid_rst_dout", {24'd0, dataout}, 0);
    @(negedge clk);
    nrst = 1'b1;
    for (int a = 0; a < 8; a++) model[a] = '0;
    rd_all();

    // 4x16 instance, reversed input: six compares in either build
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      wr4 = 1'b1; addr4 = a[1:0]; datain4 = 16'(4 - a);
    end
    @(negedge clk);
    wr4 = 1'b0; start4 = 1'b1; descend4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    cycles = 0;
    while (ready4 === 1'b0 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    check("sort4_len", cycles, 6);
    check("sort4_done", {31'd0, done4}, 1);
    for (int a = 0; a < 4; a++) model4[a] = 16'(a + 1);
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      addr4 = a[1:0];
      exp_q.push_back({16'd0, model4[a]});
      @(posedge clk); #1;
      pop_check("rd4", {16'd0, dataout4});
    end

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
